step_pulse_gen: RTL and testbench
=================================

// Module: step_pulse_gen
// PURPOSE
//  Pedometer stimulus stage: debounces start button, generates one-cycle step pulses at mode rate
//  (walk/jog/run/hybrid) and a one-cycle 1-second tick, both in the CLK domain.
//  Directly upstream of the step/second counters: drives their steps and secClk inputs.
// PARAMETERS
//  CLK_HZ      100_000_000  CLK cycles per second; step-rate and second-tick divisor
//  DEB_CYCLES  1_000_000    cycles start_btn must be stable before accepted
// PORTS
//  CLK          in   1  system clock, all logic on posedge
//  reset        in   1  synchronous, active-low reset
//  start_btn    in   1  raw pushbutton, asynchronous, bouncy
//  mode         in   2  0 walk 32/s, 1 jog 64/s, 2 run 128/s, 3 hybrid
//  steps        out  1  one-CLK step pulse
//  sec_tick     out  1  one-CLK pulse at end of each running second
//  running      out  1  generator active
//  sec_elapsed  out  8  completed seconds since start, saturates at 255
//  rate         out  8  steps/s in force for current second
// BEHAVIOUR
//  Reset (reset==0 at posedge CLK): all outputs 0, accumulators/counters 0, debounced button 0.
//  Input sync: start_btn through 2-flop synchronizer; debounce counter reloads on change, accepts
//   new level after DEB_CYCLES stable cycles. Rising edge of debounced level toggles running.
//  Start (running 0->1): sec_elapsed=0, cycle counter=0, step accumulator=0, rate loaded from
//   mode for second 0 on the same edge. Stop (1->0): steps/sec_tick forced 0, counters frozen.
//  Second timer: cyc counts 0..CLK_HZ-1 while running; on cyc==CLK_HZ-1: sec_tick=1, cyc=0,
//   sec_elapsed+1 (sat. 255), rate reloaded from mode/schedule for the new second.
//  Step generation: acc width >= clog2(CLK_HZ+256). Each running cycle: sum=acc+rate;
//   if sum>=CLK_HZ -> steps=1, acc=sum-CLK_HZ, else acc=sum. On sec_tick cycle pulse decided from
//   sum first, then acc cleared to 0. Result: exactly rate pulses per second window, at most one per
//   cycle, last pulse coincides with sec_tick.
//  mode changes mid-second take effect only at next sec_tick (or next start).
//  Hybrid schedule (rate by second index s = sec_elapsed value for the second being generated):
//   s0:20 s1:33 s2:66 s3:27 s4:70 s5:30 s6:19 s7:30 s8:33 s9-72:69 s73-78:34 s79-143:124 s>=144:0.
//  Rate 0: no steps, sec_tick continues. Outputs registered; latency start edge -> first
//   cycle counted = 1 CLK after debounced edge.
//  Button edge coincident with sec_tick while running: stop wins, no further pulses.
//  Reset mid-run: immediate return to reset state on that edge.
// CONFIGURATION
//  HYBRID_MODE_EN defined: mode 3 follows hybrid schedule above.
//  HYBRID_MODE_EN undefined: schedule ROM omitted; mode 3 gives rate=0 (ticks only, no steps).
// TESTING  (CLK_HZ=1000, DEB_CYCLES=4)
//  Reset held 3 cycles, then released -> all outputs 0, no pulses for 2000 cycles without button.
//  start_btn bounces 0/1 every 2 cycles for 20 cycles then steady 1 -> running=1 exactly once,
//   6..7 cycles after steady level; release and re-press -> running=0.
//  mode=0, start, run 3 s -> exactly 32 steps between consecutive sec_tick, sec_elapsed=3.
//  mode=0 during s0, switch to 2 mid-second -> s0 has 32 steps, s1 has 128, rate=128 after tick.
//  mode=3 with HYBRID_MODE_EN, run 150 s -> per-second counts 20,33,66,27,... 124 at s79, 0 at s144;
//   without macro -> 0 steps, 150 ticks.
//  reset low for one cycle at cycle 500 of s1 -> all outputs 0 next cycle, running=0.

Source files
------------

// File: rtl/step_pulse_gen_if.sv
// step_pulse_gen_if: start button/mode inputs and step/second-tick outputs of the pedometer stimulus stage
interface step_pulse_gen_if;
  logic       start_btn;
  logic [1:0] mode;
  logic       steps;
  logic       sec_tick;
  logic       running;
  logic [7:0] sec_elapsed;
  logic [7:0] rate;
  modport master (output start_btn, mode, input steps, sec_tick, running, sec_elapsed, rate);
  modport slave (input start_btn, mode, output steps, sec_tick, running, sec_elapsed, rate);
endinterface

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: debounced start/stop toggle, mode-rate step pulses and a 1 s tick.
// Define HYBRID_MODE_EN to make mode 3 follow the hybrid per-second schedule (otherwise mode 3 gives rate 0).
module step_pulse_gen #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input logic             CLK,
  input logic             reset,
  step_pulse_gen_if.slave bus
);
  localparam int AW = $clog2(CLK_HZ + 256);
  localparam int CW = $clog2(CLK_HZ);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [AW-1:0] HZ = AW'(CLK_HZ);
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  logic [1:0]    sync_q, sync_d;
  logic          deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          run_q, run_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [7:0]    sec_q, sec_d, rate_q, rate_d;
  logic          step_q, step_d, tick_q, tick_d;
  logic [AW-1:0] sum;
  logic [7:0]    sec_nxt, new_rate;
  logic          accept, toggle, fire, last;
`ifdef HYBRID_MODE_EN
  logic [7:0] sidx, hyb;
  // schedule index is 0 on a start edge, otherwise the second about to begin
  always_comb sidx = run_q ? sec_nxt : 8'd0;
  always_comb begin
    case (sidx)
      8'd0: hyb = 8'd20;
      8'd1: hyb = 8'd33;
      8'd2: hyb = 8'd66;
      8'd3: hyb = 8'd27;
      8'd4: hyb = 8'd70;
      8'd5: hyb = 8'd30;
      8'd6: hyb = 8'd19;
      8'd7: hyb = 8'd30;
      8'd8: hyb = 8'd33;
      default: hyb = sidx < 8'd73 ? 8'd69 : sidx < 8'd79 ? 8'd34 : sidx < 8'd144 ? 8'd124 : 8'd0;
    endcase
  end
  assign new_rate = bus.mode == 2'd3 ? hyb : 8'd32 << bus.mode;
`else
  assign new_rate = bus.mode == 2'd3 ? 8'd0 : 8'd32 << bus.mode;
`endif
  always_comb begin
    sync_d    = {sync_q[0], bus.start_btn};
    accept    = sync_q[1] != deb_q && deb_cnt_q == DEB_LAST;
    deb_d     = accept ? sync_q[1] : deb_q;
    deb_cnt_d = (sync_q[1] == deb_q || accept) ? '0 : deb_cnt_q + 1'b1;
    toggle    = accept & sync_q[1];
    run_d     = run_q ^ toggle;
    sum       = acc_q + AW'(rate_q);
    fire      = sum >= HZ;
    last      = cyc_q == LAST;
    sec_nxt   = sec_q == 8'hff ? sec_q : sec_q + 8'd1;
    cyc_d     = cyc_q;
    acc_d     = acc_q;
    sec_d     = sec_q;
    rate_d    = rate_q;
    step_d    = 1'b0;
    tick_d    = 1'b0;
    if (toggle && !run_q) begin
      cyc_d  = '0;
      acc_d  = '0;
      sec_d  = '0;
      rate_d = new_rate;
    end else if (run_q && !toggle) begin
      // a stop edge suppresses this cycle's pulse and tick and freezes the counters
      step_d = fire;
      tick_d = last;
      cyc_d  = last ? '0 : cyc_q + 1'b1;
      acc_d  = last ? '0 : fire ? sum - HZ : sum;
      sec_d  = last ? sec_nxt : sec_q;
      rate_d = last ? new_rate : rate_q;
    end
  end
  always_ff @(posedge CLK) begin
    if (!reset) begin
      sync_q    <= '0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      run_q     <= 1'b0;
      cyc_q     <= '0;
      acc_q     <= '0;
      sec_q     <= '0;
      rate_q    <= '0;
      step_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      run_q     <= run_d;
      cyc_q     <= cyc_d;
      acc_q     <= acc_d;
      sec_q     <= sec_d;
      rate_q    <= rate_d;
      step_q    <= step_d;
      tick_q    <= tick_d;
    end
  end
  assign bus.steps       = step_q;
  assign bus.sec_tick    = tick_q;
  assign bus.running     = run_q;
  assign bus.sec_elapsed = sec_q;
  assign bus.rate        = rate_q;
endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: step_pulse_gen checked against a per-second rate model; second instance
// at a lower clock rate covers the 150-second hybrid schedule.
module tb_step_pulse_gen;
  localparam int HZ1 = 1000, HZ2 = 200;
  localparam int ENDS [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 73, 79, 144};
  localparam int RTS  [12] = '{20, 33, 66, 27, 70, 30, 19, 30, 33, 69, 34, 124};
`ifdef HYBRID_MODE_EN
  localparam bit HYB = 1'b1;
`else
  localparam bit HYB = 1'b0;
`endif
  logic CLK = 1'b0;
  logic reset = 1'b0;
  int total = 0, bad = 0;
  logic [1:0] stp, tck, run;
  logic [7:0] se [2];
  logic [7:0] rt [2];
  step_pulse_gen_if b1 ();
  step_pulse_gen_if b2 ();
  step_pulse_gen #(.CLK_HZ(HZ1), .DEB_CYCLES(4)) dut  (.CLK(CLK), .reset(reset), .bus(b1));
  step_pulse_gen #(.CLK_HZ(HZ2), .DEB_CYCLES(4)) dut2 (.CLK(CLK), .reset(reset), .bus(b2));
  assign stp = {b2.steps, b1.steps};
  assign tck = {b2.sec_tick, b1.sec_tick};
  assign run = {b2.running, b1.running};
  assign se[0] = b1.sec_elapsed;
  assign se[1] = b2.sec_elapsed;
  assign rt[0] = b1.rate;
  assign rt[1] = b2.rate;
  always #5 CLK = ~CLK;
  // steps expected in second s when mode m was in force at that second's start
  function automatic int model(input int m, input int s);
    if (m < 3) return 32 << m;
    if (HYB) for (int i = 0; i < 12; i++) if (s < ENDS[i]) return RTS[i];
    return 0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag, input int d);
    chk({tag, ".steps"}, stp[d], 0);
    chk({tag, ".sec_tick"}, tck[d], 0);
    chk({tag, ".running"}, run[d], 0);
    chk({tag, ".sec_elapsed"}, se[d], 0);
    chk({tag, ".rate"}, rt[d], 0);
  endtask
  task automatic set_btn(input int d, input logic v);
    if (d == 1) b2.start_btn = v; else b1.start_btn = v;
  endtask
  task automatic set_mode(input int d, input logic [1:0] m);
    if (d == 1) b2.mode = m; else b1.mode = m;
  endtask
  task automatic press(input int d, input logic want);
    set_btn(d, 1'b0);
    repeat (8) @(negedge CLK);
    set_btn(d, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (run[d] == want) break;
    end
    chk($sformatf("press%0d_running", d), run[d], want);
  endtask
  task automatic run_sec(input int d, input int at, input logic [1:0] nm, output int cnt, output logic lst);
    cnt = 0;
    lst = 1'b0;
    for (int c = 1; c <= (d == 1 ? HZ2 : HZ1) + 20; c++) begin
      @(negedge CLK);
      if (c == at) set_mode(d, nm);
      if (stp[d]) cnt++;
      if (tck[d]) begin
        lst = stp[d];
        return;
      end
    end
    cnt = -1;
  endtask
  initial begin
    int lat, tgl, cnt, q, cm, nm, at, ex;
    logic lst, prev;
    b1.start_btn = 1'b0; b1.mode = 2'd0;
    b2.start_btn = 1'b0; b2.mode = 2'd0;
    repeat (3) @(negedge CLK);
    chk_idle("in_reset", 0);
    reset = 1'b1;
    @(negedge CLK);
    chk_idle("after_reset", 0);
    q = 0;
    repeat (2000) begin
      @(negedge CLK);
      q += stp[0] + tck[0] + run[0];
    end
    chk("idle_quiet", q, 0);
    // bouncy press: 1..3-cycle segments, ending low, then steady high
    prev = 1'b0; tgl = 0; lat = -1;
    for (int seg = 0; seg < 8; seg++) begin
      set_btn(0, seg % 2 == 0);
      repeat ($urandom_range(1, 3)) begin
        @(negedge CLK);
        if (run[0] != prev) tgl++;
        prev = run[0];
      end
    end
    set_btn(0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (run[0] != prev) begin
        tgl++;
        if (lat < 0) lat = i;
      end
      prev = run[0];
    end
    chk("bounce_toggles", tgl, 1);
    chk("start_latency_in_6_7", lat >= 6 && lat <= 7, 1);
    for (int s = 0; s < 3; s++) begin
      run_sec(0, -1, 2'd0, cnt, lst);
      chk($sformatf("walk_cnt_s%0d", s), cnt, model(0, s));
      chk($sformatf("walk_last_s%0d", s), lst, 1);
    end
    chk("walk_sec_elapsed", se[0], 3);
    chk("walk_rate", rt[0], 32);
    press(0, 1'b0);
    q = 0;
    repeat (1200) begin
      @(negedge CLK);
      q += stp[0] + tck[0];
    end
    chk("stopped_quiet", q, 0);
    chk("stopped_sec_frozen", se[0], 3);
    // mode change mid-second applies from the next second
    set_mode(0, 2'd0);
    press(0, 1'b1);
    run_sec(0, 500, 2'd2, cnt, lst);
    chk("switch_cnt_s0", cnt, model(0, 0));
    chk("switch_rate_s1", rt[0], model(2, 1));
    run_sec(0, -1, 2'd2, cnt, lst);
    chk("switch_cnt_s1", cnt, model(2, 1));
    chk("switch_last_s1", lst, 1);
    chk("switch_sec_elapsed", se[0], 2);
    press(0, 1'b0);
    // stop edge lands on the tick edge of second 0
    set_mode(0, 2'd0);
    press(0, 1'b1);
    cnt = 0; q = 0;
    for (int c = 1; c <= HZ1; c++) begin
      @(negedge CLK);
      if (stp[0]) cnt++;
      if (tck[0]) q++;
      if (c == 900) set_btn(0, 1'b0);
      if (c == 994) set_btn(0, 1'b1);
      if (c == HZ1 - 1) chk("coincide_pre_running", run[0], 1);
    end
    chk("coincide_steps", cnt, model(0, 0) - 1);
    chk("coincide_ticks", q, 0);
    chk("coincide_running", run[0], 0);
    // random modes, changed at random points mid-second
    cm = $urandom_range(0, 3);
    set_mode(0, 2'(cm));
    press(0, 1'b1);
    for (int s = 0; s < 6; s++) begin
      nm = $urandom_range(0, 3);
      at = $urandom_range(100, 800);
      run_sec(0, at, 2'(nm), cnt, lst);
      ex = model(cm, s);
      chk($sformatf("rand_cnt_s%0d_m%0d", s, cm), cnt, ex);
      chk($sformatf("rand_last_s%0d", s), lst, ex > 0);
      chk($sformatf("rand_rate_s%0d_m%0d", s + 1, nm), rt[0], model(nm, s + 1));
      cm = nm;
    end
    chk("rand_sec_elapsed", se[0], 6);
    press(0, 1'b0);
    // reset pulse at cycle 500 of second 1
    set_mode(0, 2'd0);
    press(0, 1'b1);
    run_sec(0, -1, 2'd0, cnt, lst);
    repeat (500) @(negedge CLK);
    set_btn(0, 1'b0);
    reset = 1'b0;
    @(negedge CLK);
    chk_idle("midrun_reset", 0);
    reset = 1'b1;
    // 150 seconds of mode 3 on the slow instance
    set_mode(1, 2'd3);
    press(1, 1'b1);
    for (int s = 0; s < 150; s++) begin
      run_sec(1, -1, 2'd3, cnt, lst);
      chk($sformatf("hybrid_cnt_s%0d", s), cnt, model(3, s));
    end
    chk("hybrid_sec_elapsed", se[1], 150);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
